mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Shares the single RAM port between the instruction and data request channels of all CPU caches.
- Sits between the per-CPU cache blocks, which drive the iREN/dREN/dWEN request signals, and the RAM model.
- Sequences one RAM transaction at a time and returns per-requester wait/load.
- Data requests beat instruction requests. Round-robin between CPUs within each class.

Parameters:
CPUS, 2, number of CPU request ports (each port has one I channel and one D channel)
WORD_W, 32, address/data word width
ERR_WORD, 32'hBAD1BAD1, load value returned when RAM reports ERROR

Ports:
CLK  in  1  clock, rising edge
RST  in  1  reset, asynchronous, active-high
iREN  in  CPUS  instruction read request per CPU
iaddr  in  CPUS*WORD_W  instruction address per CPU (CPU n at bits n*WORD_W +: WORD_W)
dREN  in  CPUS  data read request per CPU
dWEN  in  CPUS  data write request per CPU
daddr  in  CPUS*WORD_W  data address per CPU
dstore  in  CPUS*WORD_W  data write value per CPU
iwait  out  CPUS  1 = instruction access not complete
dwait  out  CPUS  1 = data access not complete
iload  out  CPUS*WORD_W  instruction read data
dload  out  CPUS*WORD_W  data read data
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  WORD_W  RAM address
ramstore  out  WORD_W  RAM write data
ramload  in  WORD_W  RAM read data
ramstate  in  2  RAM status: FREE=00, BUSY=01, ACCESS=10, ERROR=11
busy  out  1  1 while a transaction is outstanding

Behaviour:
- Reset, asynchronous:
  - state=IDLE, ramREN=ramWEN=0, ramaddr=ramstore=0.
  - All iwait/dwait=1, iload/dload=0, busy=0.
  - Both round-robin pointers point to CPU0.
  - Asserting reset mid-transaction aborts it at once. No completion is signalled.
- FSM states: IDLE, XFER.
- IDLE:
  - Arbitrate among pending requests: dREN|dWEN for the data class, iREN for the instruction class.
  - Any data request wins over all instruction requests.
  - Within a class, the winner is the first requesting CPU at or after that class's rr pointer, wrapping CPUS-1 -> 0.
  - On a win, register: owner, class, address, store data, write flag (dWEN has priority over dREN from the same CPU). Go to XFER next cycle.
  - No request: stay in IDLE.
- XFER:
  - ramREN/ramWEN/ramaddr/ramstore are driven only from the registered values, stable for the whole transaction. busy=1.
  - ramstate FREE or BUSY: stay in XFER.
  - ramstate ACCESS:
    - Same cycle, combinational: the owner's iwait or dwait=0.
    - For reads, the owner's iload/dload=ramload in that cycle.
    - Next edge: go to IDLE and advance that class's rr pointer to owner+1 mod CPUS.
  - ramstate ERROR: same as ACCESS, except load=ERR_WORD.
- Loads: each iload/dload lane holds its last delivered value until its next completion. Writes do not change dload.
- Latency: minimum 2 cycles from request to wait low (1 arbitration cycle + 1 RAM cycle). There is always a 1-cycle IDLE bubble between transactions.
- Request retraction: if the owner drops its request during XFER, the transaction still completes on the RAM. The wait pulse is still produced and is ignored.
- Requesters hold request/address/data until they see their wait low. A request still held in the following IDLE cycle is treated as a new request.
- Wait signals: at most one wait bit of all 2*CPUS is low in any cycle. It is low for exactly one cycle per transaction.
- Starvation bound: with all channels saturated, each data channel is served within CPUS transactions. Instruction channels are served only when no data request is pending.

Optional Feature:
MEMARB_PERF_EN
- Defined:
  - Adds outputs dgrant_cnt and igrant_cnt (32 bits each, saturating) and stall_cnt (32 bits, saturating).
  - dgrant_cnt / igrant_cnt increment on each data / instruction completion.
  - stall_cnt increments on each cycle in XFER where ramstate is FREE or BUSY.
  - All counters clear on RST.
- Undefined: the counters and ports are absent. No other behaviour changes.

Test Plan:
1. CPU0 iREN, iaddr=0x40; RAM returns ACCESS after 3 BUSY cycles with ramload=0x8C010004 -> ramaddr=0x40, ramREN=1 for 4 cycles; iwait[0]=0 for exactly 1 cycle; iload[0]=0x8C010004 and held afterwards.
2. CPU0 iREN and CPU1 dWEN (daddr=0x100, dstore=0xDEADBEEF) in the same cycle -> data served first: ramWEN=1, ramaddr=0x100, ramstore=0xDEADBEEF; dwait[1] pulses low. Then, after the IDLE bubble, the instruction fetch runs.
3. CPU0 and CPU1 both hold dREN continuously, RAM responds in 1 cycle -> grants alternate 0,1,0,1; dwait pulses are never in the same cycle.
4. ramstate=ERROR on a CPU1 dREN -> dwait[1]=0 for 1 cycle with dload[1]=0xBAD1BAD1; FSM returns to IDLE.
5. RST asserted during XFER -> ramREN/ramWEN go to 0 asynchronously and all waits read 1. After release with no requests, busy=0 and no wait pulse occurs.
6. CPU0 drops dREN mid-XFER -> RAM access still completes; dwait[0] pulses once; the next grant goes to the next pending requester.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the per-CPU cache request channels, the RAM port and the arbiter.
// The perf counter signals exist only when MEMARB_PERF_EN is defined.
interface mem_arbiter_if #(
  parameter int CPUS   = 2,
  parameter int WORD_W = 32
);
  logic [CPUS-1:0]        iREN;
  logic [CPUS*WORD_W-1:0] iaddr;
  logic [CPUS-1:0]        dREN;
  logic [CPUS-1:0]        dWEN;
  logic [CPUS*WORD_W-1:0] daddr;
  logic [CPUS*WORD_W-1:0] dstore;
  logic [CPUS-1:0]        iwait;
  logic [CPUS-1:0]        dwait;
  logic [CPUS*WORD_W-1:0] iload;
  logic [CPUS*WORD_W-1:0] dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;
  logic                   busy;
`ifdef MEMARB_PERF_EN
  logic [31:0]            dgrant_cnt;
  logic [31:0]            igrant_cnt;
  logic [31:0]            stall_cnt;
`endif

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy
`ifdef MEMARB_PERF_EN
    , output dgrant_cnt, igrant_cnt, stall_cnt
`endif
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, busy
`ifdef MEMARB_PERF_EN
    , input dgrant_cnt, igrant_cnt, stall_cnt
`endif
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: data channels beat instruction channels, round-robin per class.
// Define MEMARB_PERF_EN to add saturating grant/stall counters.
module mem_arbiter #(
  parameter int                CPUS     = 2,
  parameter int                WORD_W   = 32,
  parameter logic [WORD_W-1:0] ERR_WORD = 32'hBAD1BAD1
) (
  input  logic         CLK,
  input  logic         RST,
  mem_arbiter_if.slave bus
);
  localparam int CW = (CPUS > 1) ? $clog2(CPUS) : 1;

  typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t                 state_r, state_nxt_s;
  logic [CW-1:0]          owner_r, irr_r, drr_r;
  logic                   cls_r, wr_r, ren_r, wen_r, busy_r;
  logic [WORD_W-1:0]      addr_r, store_r;
  logic [CPUS*WORD_W-1:0] iload_r, dload_r, iload_s, dload_s;
  logic [CPUS-1:0]        iwait_s, dwait_s, dreq_s;
  logic [CW:0]            dpick_s, ipick_s;
  logic                   win_s, win_cls_s, done_s;
  logic [CW-1:0]          win_idx_s;
  logic [WORD_W-1:0]      ld_val_s;

  // First requester at or after ptr, wrapping; MSB flags a valid pick.
  function automatic logic [CW:0] rr_pick(input logic [CPUS-1:0] req, input logic [CW-1:0] ptr);
    logic [CW:0] res;
    int          idx;
    res = '0;
    for (int i = CPUS - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % CPUS;
      if (req[idx]) res = {1'b1, CW'(idx)};
    end
    return res;
  endfunction

  function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] ptr);
    return (int'(ptr) == CPUS - 1) ? '0 : ptr + CW'(1'b1);
  endfunction

  // Arbitration between classes and within each class
  always_comb begin
    dreq_s  = bus.dREN | bus.dWEN;
    dpick_s = rr_pick(dreq_s, drr_r);
    ipick_s = rr_pick(bus.iREN, irr_r);
    if (dpick_s[CW]) begin
      win_cls_s = 1'b1;
      win_idx_s = dpick_s[CW-1:0];
    end else begin
      win_cls_s = 1'b0;
      win_idx_s = ipick_s[CW-1:0];
    end
    win_s = (state_r == IDLE) && (dpick_s[CW] || ipick_s[CW]);
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = win_s ? XFER : IDLE;
      XFER:    state_nxt_s = bus.ramstate[1] ? IDLE : XFER;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Completion outputs: wait pulse and load bypass in the ACCESS/ERROR cycle
  always_comb begin
    done_s   = (state_r == XFER) && bus.ramstate[1];
    ld_val_s = (bus.ramstate == 2'b11) ? ERR_WORD : bus.ramload;
    iwait_s  = '1;
    dwait_s  = '1;
    iload_s  = iload_r;
    dload_s  = dload_r;
    if (done_s) begin
      if (cls_r) begin
        dwait_s[owner_r] = 1'b0;
        if (!wr_r) dload_s[owner_r*WORD_W +: WORD_W] = ld_val_s;
        else       dload_s = dload_r;
      end else begin
        iwait_s[owner_r] = 1'b0;
        iload_s[owner_r*WORD_W +: WORD_W] = ld_val_s;
      end
    end else begin
      iwait_s = '1;
      dwait_s = '1;
    end
  end

  // Transaction capture, RAM drive registers, rr pointers and load lanes
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      owner_r <= '0;
      irr_r   <= '0;
      drr_r   <= '0;
      cls_r   <= 1'b0;
      wr_r    <= 1'b0;
      ren_r   <= 1'b0;
      wen_r   <= 1'b0;
      busy_r  <= 1'b0;
      addr_r  <= '0;
      store_r <= '0;
      iload_r <= '0;
      dload_r <= '0;
    end else begin
      iload_r <= iload_s;
      dload_r <= dload_s;
      if (win_s) begin
        owner_r <= win_idx_s;
        cls_r   <= win_cls_s;
        busy_r  <= 1'b1;
        if (win_cls_s) begin
          addr_r  <= bus.daddr[win_idx_s*WORD_W +: WORD_W];
          store_r <= bus.dstore[win_idx_s*WORD_W +: WORD_W];
          wr_r    <= bus.dWEN[win_idx_s];
          ren_r   <= ~bus.dWEN[win_idx_s];
          wen_r   <= bus.dWEN[win_idx_s];
        end else begin
          addr_r  <= bus.iaddr[win_idx_s*WORD_W +: WORD_W];
          store_r <= '0;
          wr_r    <= 1'b0;
          ren_r   <= 1'b1;
          wen_r   <= 1'b0;
        end
      end else if (done_s) begin
        ren_r  <= 1'b0;
        wen_r  <= 1'b0;
        busy_r <= 1'b0;
        if (cls_r) drr_r <= rr_next(owner_r);
        else       irr_r <= rr_next(owner_r);
      end else begin
        busy_r <= busy_r;
      end
    end
  end

  assign bus.iwait    = iwait_s;
  assign bus.dwait    = dwait_s;
  assign bus.iload    = iload_s;
  assign bus.dload    = dload_s;
  assign bus.ramREN   = ren_r;
  assign bus.ramWEN   = wen_r;
  assign bus.ramaddr  = addr_r;
  assign bus.ramstore = store_r;
  assign bus.busy     = busy_r;

`ifdef MEMARB_PERF_EN
  logic [31:0] dgrant_cnt_r, igrant_cnt_r, stall_cnt_r;

  // Saturating performance counters
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dgrant_cnt_r <= 32'd0;
      igrant_cnt_r <= 32'd0;
      stall_cnt_r  <= 32'd0;
    end else begin
      if (done_s && cls_r && (dgrant_cnt_r != 32'hFFFF_FFFF)) dgrant_cnt_r <= dgrant_cnt_r + 32'd1;
      else                                                   dgrant_cnt_r <= dgrant_cnt_r;
      if (done_s && !cls_r && (igrant_cnt_r != 32'hFFFF_FFFF)) igrant_cnt_r <= igrant_cnt_r + 32'd1;
      else                                                    igrant_cnt_r <= igrant_cnt_r;
      if ((state_r == XFER) && !bus.ramstate[1] && (stall_cnt_r != 32'hFFFF_FFFF)) stall_cnt_r <= stall_cnt_r + 32'd1;
      else                                                                          stall_cnt_r <= stall_cnt_r;
    end
  end

  assign bus.dgrant_cnt = dgrant_cnt_r;
  assign bus.igrant_cnt = igrant_cnt_r;
  assign bus.stall_cnt  = stall_cnt_r;
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter; the bench plays the RAM by driving ramstate/ramload.
module tb_mem_arbiter;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  mem_arbiter_if #(.CPUS(2), .WORD_W(32)) bus ();

  mem_arbiter #(.CPUS(2), .WORD_W(32)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    bus.iREN = 2'b00; bus.dREN = 2'b00; bus.dWEN = 2'b00;
    bus.iaddr = 64'd0; bus.daddr = 64'd0; bus.dstore = 64'd0;
    bus.ramload = 32'd0; bus.ramstate = 2'b00;
    #1 rst = 1'b1;
    #2;
    chk("rst_ramREN", bus.ramREN, 64'd0);
    chk("rst_ramWEN", bus.ramWEN, 64'd0);
    chk("rst_ramaddr", bus.ramaddr, 64'd0);
    chk("rst_ramstore", bus.ramstore, 64'd0);
    chk("rst_iwait", bus.iwait, 64'h3);
    chk("rst_dwait", bus.dwait, 64'h3);
    chk("rst_iload", bus.iload, 64'd0);
    chk("rst_dload", bus.dload, 64'd0);
    chk("rst_busy", bus.busy, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: single fetch, three BUSY cycles then ACCESS
    bus.iREN = 2'b01; bus.iaddr = {32'h0, 32'h40}; bus.ramstate = 2'b01;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      chk("t1_ramREN_busy", bus.ramREN, 64'd1);
      chk("t1_ramaddr", bus.ramaddr, 64'h40);
      chk("t1_iwait_busy", bus.iwait, 64'h3);
      chk("t1_busy", bus.busy, 64'd1);
    end
    tick();
    bus.ramstate = 2'b10; bus.ramload = 32'h8C010004;
    #1;
    chk("t1_ramREN_access", bus.ramREN, 64'd1);
    chk("t1_iwait_low", bus.iwait, 64'h2);
    chk("t1_dwait_high", bus.dwait, 64'h3);
    chk("t1_iload", bus.iload[31:0], 64'h8C010004);
    tick();
    bus.iREN = 2'b00; bus.ramstate = 2'b00; bus.ramload = 32'hFFFF0000;
    #1;
    chk("t1_ramREN_off", bus.ramREN, 64'd0);
    chk("t1_busy_off", bus.busy, 64'd0);
    chk("t1_iwait_back", bus.iwait, 64'h3);
    chk("t1_iload_held", bus.iload[31:0], 64'h8C010004);

    // 2: data write beats simultaneous instruction fetch
    bus.iREN = 2'b01; bus.iaddr = {32'h0, 32'h80};
    bus.dWEN = 2'b10; bus.daddr = {32'h100, 32'h0}; bus.dstore = {32'hDEADBEEF, 32'h0};
    tick();
    #1;
    chk("t2_ramWEN", bus.ramWEN, 64'd1);
    chk("t2_ramREN", bus.ramREN, 64'd0);
    chk("t2_ramaddr", bus.ramaddr, 64'h100);
    chk("t2_ramstore", bus.ramstore, 64'hDEADBEEF);
    chk("t2_dwait_free", bus.dwait, 64'h3);
    tick();
    bus.ramstate = 2'b10; bus.ramload = 32'h12345678;
    #1;
    chk("t2_dwait_low", bus.dwait, 64'h1);
    chk("t2_iwait_high", bus.iwait, 64'h3);
    chk("t2_dload_unchanged", bus.dload, 64'd0);
    tick();
    bus.dWEN = 2'b00; bus.ramstate = 2'b00;
    #1;
    chk("t2_bubble_busy", bus.busy, 64'd0);
    chk("t2_bubble_wen", bus.ramWEN, 64'd0);
    tick();
    #1;
    chk("t2_fetch_ren", bus.ramREN, 64'd1);
    chk("t2_fetch_addr", bus.ramaddr, 64'h80);
    bus.ramstate = 2'b10; bus.ramload = 32'h11112222;
    #1;
    chk("t2_fetch_iwait", bus.iwait, 64'h2);
    tick();
    bus.iREN = 2'b00; bus.ramstate = 2'b00;
    #1;
    chk("t2_fetch_iload", bus.iload[31:0], 64'h11112222);

    // 3: both CPUs saturate dREN with single-cycle RAM -> alternate grants
    bus.dREN = 2'b11; bus.daddr = {32'h300, 32'h200}; bus.ramstate = 2'b10;
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.ramload = 32'hA0000000 + 32'(k);
      #1;
      if ((k % 2) == 0) begin
        chk("t3_dwait_cpu0", bus.dwait, 64'h2);
        chk("t3_addr_cpu0", bus.ramaddr, 64'h200);
        chk("t3_dload_cpu0", bus.dload[31:0], 64'hA0000000 + 64'(k));
      end else begin
        chk("t3_dwait_cpu1", bus.dwait, 64'h1);
        chk("t3_addr_cpu1", bus.ramaddr, 64'h300);
        chk("t3_dload_cpu1", bus.dload[63:32], 64'hA0000000 + 64'(k));
      end
      tick();
      #1;
      chk("t3_bubble_dwait", bus.dwait, 64'h3);
    end
    bus.dREN = 2'b00;

    // 4: RAM ERROR on CPU1 read
    bus.dREN = 2'b10; bus.daddr = {32'h44, 32'h200}; bus.ramstate = 2'b11;
    tick();
    bus.ramload = 32'h55555555;
    #1;
    chk("t4_dwait", bus.dwait, 64'h1);
    chk("t4_dload_err", bus.dload[63:32], 64'hBAD1BAD1);
    chk("t4_iwait", bus.iwait, 64'h3);
    tick();
    bus.dREN = 2'b00; bus.ramstate = 2'b00;
    #1;
    chk("t4_idle_busy", bus.busy, 64'd0);
    chk("t4_idle_ren", bus.ramREN, 64'd0);
    chk("t4_dload_held", bus.dload[63:32], 64'hBAD1BAD1);

    // 5: reset during XFER aborts asynchronously
    bus.dREN = 2'b01; bus.daddr = {32'h0, 32'h500}; bus.ramstate = 2'b01;
    tick();
    chk("t5_pre_ren", bus.ramREN, 64'd1);
    rst = 1'b1;
    #1;
    chk("t5_rst_ren", bus.ramREN, 64'd0);
    chk("t5_rst_wen", bus.ramWEN, 64'd0);
    chk("t5_rst_dwait", bus.dwait, 64'h3);
    chk("t5_rst_iwait", bus.iwait, 64'h3);
    chk("t5_rst_busy", bus.busy, 64'd0);
    bus.dREN = 2'b00;
    tick();
    rst = 1'b0; bus.ramstate = 2'b10;
    #1;
    chk("t5_rel_dwait", bus.dwait, 64'h3);
    tick();
    chk("t5_rel_busy", bus.busy, 64'd0);
    chk("t5_rel_dwait2", bus.dwait, 64'h3);
    chk("t5_rel_ren", bus.ramREN, 64'd0);
    bus.ramstate = 2'b00;

    // 6: CPU0 retracts mid-XFER; access completes, then CPU1 is granted
    bus.dREN = 2'b11; bus.daddr = {32'h700, 32'h600}; bus.ramstate = 2'b01;
    tick();
    bus.dREN = 2'b10;
    #1;
    chk("t6_addr0", bus.ramaddr, 64'h600);
    chk("t6_ren_held", bus.ramREN, 64'd1);
    chk("t6_dwait_busy", bus.dwait, 64'h3);
    tick();
    bus.ramstate = 2'b10; bus.ramload = 32'h66666666;
    #1;
    chk("t6_dwait0", bus.dwait, 64'h2);
    chk("t6_dload0", bus.dload[31:0], 64'h66666666);
    tick();
    bus.ramstate = 2'b01;
    #1;
    chk("t6_bubble_dwait", bus.dwait, 64'h3);
    chk("t6_bubble_busy", bus.busy, 64'd0);
    tick();
    #1;
    chk("t6_addr1", bus.ramaddr, 64'h700);
    bus.ramstate = 2'b10;
    #1;
    chk("t6_dwait1", bus.dwait, 64'h1);
    tick();
    bus.dREN = 2'b00; bus.ramstate = 2'b00;
    #1;
    chk("t6_end_busy", bus.busy, 64'd0);
    chk("t6_end_dwait", bus.dwait, 64'h3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
